// File: rtl/nios0_mul_combine.sv
// Issue/recombine stage around the three-product 16x16 multiplier cell.
// Shadows the cell register (S1) and sums partial products into an output register (S2).
module nios0_mul_combine #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_src1,
  input  logic [31:0]      in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      cell_src1,
  output logic [31:0]      cell_src2,
  output logic             cell_en,
  input  logic [31:0]      cell_p1,
  input  logic [31:0]      cell_p2,
  input  logic [31:0]      cell_p3,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag
);

  // Handshake: a transfer happens on a rising edge where valid & ready are both high;
  // valid never depends on ready, and held data stays stable until it transfers.
  logic             s1_valid;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_adv;
  logic             s1_adv;
  logic             accept;
  logic [31:0]      combined;

  assign s2_adv    = ~out_valid | out_ready;
  assign s1_adv    = ~s1_valid | s2_adv;
  assign in_ready  = s1_adv & ~flush & ~reset;
  assign accept    = in_valid & in_ready;
  assign cell_en   = s1_adv;
  assign cell_src1 = in_src1;
  assign cell_src2 = in_src2;

  // Only the low 16 bits of the cross-term sum survive the shift, giving the low word of a*b.
  assign combined = cell_p1 + ((cell_p2 + cell_p3) << 16);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_tag     <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (flush) begin
      s1_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= accept;
        if (accept) begin
          s1_tag <= in_tag;
        end
      end
      if (s1_valid && s2_adv) begin
        out_result <= combined;
        out_tag    <= s1_tag;
        out_valid  <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_nios0_mul_combine.sv
// Bench for nios0_mul_combine with a behavioural model of the multiplier cell
// and an expected-result queue checked by an independent output monitor.
module tb_nios0_mul_combine;

  localparam int TAG_W = 5;
  localparam int W = TAG_W + 32;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      in_src1 = '0;
  logic [31:0]      in_src2 = '0;
  logic [TAG_W-1:0] in_tag = '0;
  logic [31:0]      cell_src1;
  logic [31:0]      cell_src2;
  logic             cell_en;
  logic [31:0]      cell_p1 = '0;
  logic [31:0]      cell_p2 = '0;
  logic [31:0]      cell_p3 = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  nios0_mul_combine #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .cell_src1(cell_src1), .cell_src2(cell_src2), .cell_en(cell_en),
    .cell_p1(cell_p1), .cell_p2(cell_p2), .cell_p3(cell_p3),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // multiplier cell model: one enabled register stage of unsigned 16x16 products
  always_ff @(posedge clk) begin
    if (cell_en) begin
      cell_p1 <= {16'h0, cell_src1[15:0]} * {16'h0, cell_src2[15:0]};
      cell_p2 <= {16'h0, cell_src1[15:0]} * {16'h0, cell_src2[31:16]};
      cell_p3 <= {16'h0, cell_src1[31:16]} * {16'h0, cell_src2[15:0]};
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: present one operation, push expected result when it is accepted
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t,
                      input logic [31:0] r, output int waits);
    bit done;
    done = 1'b0;
    waits = 0;
    in_src1 = a;
    in_src2 = b;
    in_tag = t;
    in_valid = 1'b1;
    while (!done && waits < 100) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back({t, r});
        done = 1'b1;
      end else begin
        waits++;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout tag %0d never accepted", t);
    end
  endtask

  // monitor / scoreboard
  logic             hold_prev = 1'b0;
  logic [31:0]      held_res = '0;
  logic [TAG_W-1:0] held_tag = '0;
  logic [W-1:0]     exp_e;

  always @(negedge clk) begin
    if (!reset && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output got result 0x%0h tag %0d expected none", out_result, out_tag);
      end else begin
        exp_e = exp_q.pop_front();
        check("result", {32'h0, out_result}, {32'h0, exp_e[31:0]});
        check("tag", {59'h0, out_tag}, {59'h0, exp_e[W-1:32]});
      end
    end
    if (hold_prev && out_valid) begin
      check("stall_result_stable", {32'h0, out_result}, {32'h0, held_res});
      check("stall_tag_stable", {59'h0, out_tag}, {59'h0, held_tag});
    end
    hold_prev = out_valid && !out_ready;
    held_res = out_result;
    held_tag = out_tag;
  end

  logic [31:0] stream_exp [8] = '{32'd2, 32'd6, 32'd12, 32'd20, 32'd30, 32'd42, 32'd56, 32'd72};

  initial begin
    int w;
    // reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", {63'h0, out_valid}, 64'h0);
    check("reset_out_result", {32'h0, out_result}, 64'h0);
    check("reset_out_tag", {59'h0, out_tag}, 64'h0);
    check("reset_in_ready", {63'h0, in_ready}, 64'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_in_ready", {63'h0, in_ready}, 64'h1);
    @(posedge clk);
    #1;

    // single op with latency check
    send(32'h12345678, 32'h00000010, 5'd3, 32'h23456780, w);
    @(negedge clk);
    check("latency_s1_only", {63'h0, out_valid}, 64'h0);
    @(negedge clk);
    check("latency_out_valid", {63'h0, out_valid}, 64'h1);
    repeat (2) @(posedge clk);
    #1;

    // boundary products
    send(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 32'h00000001, w);
    send(32'h00010000, 32'h00010000, 5'd2, 32'h00000000, w);
    send(32'hFFFFFFFE, 32'h00000003, 5'd4, 32'hFFFFFFFA, w);
    repeat (4) @(posedge clk);
    #1;

    // back-to-back stream, no backpressure
    for (int i = 0; i < 8; i++) begin
      send(32'(i + 1), 32'(i + 2), 5'(i), stream_exp[i], w);
      check("stream_no_wait", 64'(w), 64'h0);
    end
    repeat (4) @(posedge clk);
    #1;

    // backpressure for 4 cycles
    out_ready = 1'b0;
    send(32'd100, 32'd200, 5'd10, 32'd20000, w);
    send(32'h00020000, 32'h00000003, 5'd11, 32'h00060000, w);
    fork
      begin
        send(32'h00000005, 32'h00030000, 5'd12, 32'h000F0000, w);
        send(32'h00000007, 32'h00000008, 5'd13, 32'd56, w);
      end
      begin
        repeat (4) begin
          @(negedge clk);
          check("stall_in_ready", {63'h0, in_ready}, 64'h0);
          check("stall_cell_en", {63'h0, cell_en}, 64'h0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (5) @(posedge clk);
    #1;
    check("stall_drained", 64'(exp_q.size()), 64'h0);

    // flush with two ops in flight
    out_ready = 1'b0;
    send(32'd2, 32'd2, 5'd5, 32'd4, w);
    send(32'd3, 32'd3, 5'd6, 32'd9, w);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("flush_out_valid", {63'h0, out_valid}, 64'h0);
    end
    @(posedge clk);
    #1;
    send(32'd3, 32'd5, 5'd9, 32'd15, w);
    @(negedge clk);
    check("flush_latency_s1", {63'h0, out_valid}, 64'h0);
    @(negedge clk);
    check("flush_latency_out", {63'h0, out_valid}, 64'h1);
    repeat (2) @(posedge clk);
    #1;

    // reset while a result is held under backpressure
    out_ready = 1'b0;
    send(32'd9, 32'd9, 5'd7, 32'd81, w);
    repeat (2) @(posedge clk);
    #1;
    check("held_before_reset", {63'h0, out_valid}, 64'h1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    @(negedge clk);
    check("mid_reset_out_valid", {63'h0, out_valid}, 64'h0);
    check("mid_reset_out_result", {32'h0, out_result}, 64'h0);
    @(posedge clk);
    #1;
    send(32'd7, 32'd6, 5'd4, 32'd42, w);
    repeat (5) @(posedge clk);
    #1;

    check("queue_empty", 64'(exp_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
